// File: rtl/painterengine_gpu_writer_scheduler.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_writer_scheduler
//
// Round-robin job scheduler in front of the shared GPU DMA writer. Four
// requesters compete for the writer. The winner's one-hot route is presented
// while the writer is still held in reset. The writer is then released, and the
// scheduler waits for done, error or a watchdog timeout. It pulses a
// per-channel ack and re-arms the writer by holding its reset low again.
//
// Handshake: i_wire_request[n] is a level. It stays high until the cycle after
// the requester sees o_wire_ack[n]. The ack is a single-cycle pulse that is
// raised only for the granted channel. The request is sampled only in IDLE.
//
// Ports
//   i_wire_clock              clock, all logic on the rising edge
//   i_wire_reset              synchronous active-high reset
//   i_wire_request[3:0]       per-channel job request (level)
//   o_wire_ack[3:0]           one-cycle completion pulse on granted channel
//   o_wire_status_error[3:0]  per-channel error flag, updated at that ack
//   o_wire_error_type[2:0]    error type of last failed job (3'b111 = timeout)
//   o_wire_busy               high whenever the scheduler is not IDLE
//   o_wire_grant_index[1:0]   current / last granted channel
//   o_wire_writer_router[3:0] one-hot route to the writer, 0 when idle
//   o_wire_writer_resetn      active-low reset to the writer
//   i_wire_writer_done        writer done level
//   i_wire_writer_error       writer error level
//   i_wire_writer_error_type  writer error type
//
// PARAM_TIMEOUT_CYCLES must be >= 1.
// PARAM_REARM_CYCLES must be >= 2, so that IDLE sees a dropped request.
// -----------------------------------------------------------------------------
module painterengine_gpu_writer_scheduler #(
   parameter int unsigned PARAM_TIMEOUT_CYCLES = 65535,
   parameter int unsigned PARAM_REARM_CYCLES   = 2
) (
   input  logic       i_wire_clock,
   input  logic       i_wire_reset,
   input  logic [3:0] i_wire_request,
   output logic [3:0] o_wire_ack,
   output logic [3:0] o_wire_status_error,
   output logic [2:0] o_wire_error_type,
   output logic       o_wire_busy,
   output logic [1:0] o_wire_grant_index,
   output logic [3:0] o_wire_writer_router,
   output logic       o_wire_writer_resetn,
   input  logic       i_wire_writer_done,
   input  logic       i_wire_writer_error,
   input  logic [2:0] i_wire_writer_error_type
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_REARM = 2'd3;

   localparam logic [15:0] TMO_LAST   = 16'(PARAM_TIMEOUT_CYCLES - 1);
   localparam logic [15:0] REARM_LAST = 16'(PARAM_REARM_CYCLES - 1);
   localparam logic [2:0]  ERR_TIMEOUT = 3'b111;

   logic [1:0]  state_q, state_d;
   logic [3:0]  router_q, router_d;
   logic        resetn_q, resetn_d;
   logic [3:0]  ack_q, ack_d;
   logic [3:0]  status_q, status_d;
   logic [2:0]  err_type_q, err_type_d;
   logic        busy_q, busy_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  rr_q, rr_d;
   logic [15:0] tmo_q, tmo_d;
   logic [15:0] rearm_q, rearm_d;

   // Round-robin pick. The scan covers rr+1 .. rr+4 (mod 4). Walking k downward
   // means the closest set bit after the pointer is the last one written, so it
   // wins.
   logic       pick_valid;
   logic [1:0] pick_idx;
   logic [1:0] cand;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = rr_q;
      cand       = rr_q;
      for (int k = 4; k >= 1; k--) begin
         cand = rr_q + 2'(k);
         if (i_wire_request[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Completion decode for RUN. Error beats done, and done beats the watchdog.
   logic       run_complete;
   logic       run_is_error;
   logic [2:0] run_err_type;

   always_comb begin
      run_complete = 1'b0;
      run_is_error = 1'b0;
      run_err_type = err_type_q;
      if (i_wire_writer_error) begin
         run_complete = 1'b1;
         run_is_error = 1'b1;
         run_err_type = i_wire_writer_error_type;
      end else if (i_wire_writer_done) begin
         run_complete = 1'b1;
      end else if (tmo_q == TMO_LAST) begin
         run_complete = 1'b1;
         run_is_error = 1'b1;
         run_err_type = ERR_TIMEOUT;
      end
   end

   always_comb begin
      state_d    = state_q;
      router_d   = router_q;
      resetn_d   = resetn_q;
      ack_d      = 4'b0000;
      status_d   = status_q;
      err_type_d = err_type_q;
      busy_d     = busy_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      tmo_d      = tmo_q;
      rearm_d    = rearm_q;

      case (state_q)
         ST_IDLE: begin
            resetn_d = 1'b0;
            router_d = 4'b0000;
            if (pick_valid) begin
               grant_d  = pick_idx;
               router_d = 4'b0001 << pick_idx;
               busy_d   = 1'b1;
               state_d  = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // The router has been stable for one cycle while the writer was in
            // reset. The writer is released now.
            resetn_d = 1'b1;
            tmo_d    = 16'd0;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            if (run_complete) begin
               ack_d             = 4'b0001 << grant_q;
               status_d[grant_q] = run_is_error;
               err_type_d        = run_err_type;
               resetn_d          = 1'b0;
               router_d          = 4'b0000;
               rr_d              = grant_q;
               rearm_d           = 16'd0;
               state_d           = ST_REARM;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ST_REARM: begin
            resetn_d = 1'b0;
            if (rearm_q == REARM_LAST) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               rearm_d = rearm_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         state_q    <= ST_IDLE;
         router_q   <= 4'b0000;
         resetn_q   <= 1'b0;
         ack_q      <= 4'b0000;
         status_q   <= 4'b0000;
         err_type_q <= 3'b000;
         busy_q     <= 1'b0;
         grant_q    <= 2'd0;
         rr_q       <= 2'd3;
         tmo_q      <= 16'd0;
         rearm_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         router_q   <= router_d;
         resetn_q   <= resetn_d;
         ack_q      <= ack_d;
         status_q   <= status_d;
         err_type_q <= err_type_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         tmo_q      <= tmo_d;
         rearm_q    <= rearm_d;
      end
   end

   assign o_wire_ack           = ack_q;
   assign o_wire_status_error  = status_q;
   assign o_wire_error_type    = err_type_q;
   assign o_wire_busy          = busy_q;
   assign o_wire_grant_index   = grant_q;
   assign o_wire_writer_router = router_q;
   assign o_wire_writer_resetn = resetn_q;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for painterengine_gpu_writer_scheduler. The watchdog is set to 8
// cycles and the re-arm window to 2 cycles. Inputs are driven, and outputs are
// sampled, on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_painterengine_gpu_writer_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] ack;
   logic [3:0] status;
   logic [2:0] et;
   logic       busy;
   logic [1:0] grant;
   logic [3:0] router;
   logic       wresetn;
   logic       done;
   logic       werr;
   logic [2:0] wet;

   int checks = 0;
   int errors = 0;

   // Expected {ack, status_error, error_type} for each pending completion.
   logic [10:0] exp_q[$];
   logic [3:0]  status_m;
   logic [2:0]  et_m;

   painterengine_gpu_writer_scheduler #(
      .PARAM_TIMEOUT_CYCLES(8),
      .PARAM_REARM_CYCLES  (2)
   ) dut (
      .i_wire_clock            (clk),
      .i_wire_reset            (rst),
      .i_wire_request          (req),
      .o_wire_ack              (ack),
      .o_wire_status_error     (status),
      .o_wire_error_type       (et),
      .o_wire_busy             (busy),
      .o_wire_grant_index      (grant),
      .o_wire_writer_router    (router),
      .o_wire_writer_resetn    (wresetn),
      .i_wire_writer_done      (done),
      .i_wire_writer_error     (werr),
      .i_wire_writer_error_type(wet)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard: every nonzero ack must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && ack !== 4'b0000) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL ack_unexpected observed=%0h expected=none", ack);
         end
         if (exp_q.size() != 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            checks++;
            assert ({ack, status, et} === e) else begin
               errors++;
               $error("FAIL sb_completion observed=%0h expected=%0h", {ack, status, et}, e);
            end
         end
      end
   end

   // Driver: one job for channel ch. The request is already driven, the DUT is
   // IDLE and the grant happens on the next rising edge.
   task automatic do_job(input int ch, input int wait_cyc, input logic d,
                         input logic e, input logic [2:0] t, input logic drop_early);
      logic [3:0] m;
      m = 4'b0001 << ch;
      status_m[ch] = e;
      if (e) et_m = t;
      exp_q.push_back({m, status_m, et_m});
      @(negedge clk);
      chk("grant_router", router, m);
      chk("grant_index", grant, ch);
      chk("grant_resetn_low", wresetn, 0);
      chk("grant_busy", busy, 1);
      @(negedge clk);
      chk("run_resetn_high", wresetn, 1);
      chk("run_router", router, m);
      if (drop_early) req[ch] = 1'b0;
      repeat (wait_cyc) @(negedge clk);
      chk("run_no_ack", ack, 0);
      done = d;
      werr = e;
      wet  = t;
      @(negedge clk);
      chk("ack_pulse", ack, m);
      chk("ack_resetn_low", wresetn, 0);
      chk("ack_router_zero", router, 0);
      req[ch] = 1'b0;
      werr = 1'b0;
      wet  = 3'b000;
      done = 1'b1;  // stray done inside REARM must be ignored
      @(negedge clk);
      done = 1'b0;
      chk("rearm_ack_low", ack, 0);
      chk("rearm_busy", busy, 1);
      @(negedge clk);
      chk("idle_busy_low", busy, 0);
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; done = 1'b0; werr = 1'b0; wet = 3'b000;
      status_m = 4'b0000; et_m = 3'b000;
      repeat (3) @(negedge clk);
      chk("rst_router", router, 0);
      chk("rst_resetn", wresetn, 0);
      chk("rst_ack", ack, 0);
      chk("rst_status", status, 0);
      chk("rst_err_type", et, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      rst = 1'b0;

      // A done pulse in IDLE must not produce an ack.
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("idle_done_ignored", {ack, busy}, 0);

      // Single job on channel 0.
      req = 4'b0001;
      do_job(0, 6, 1'b1, 1'b0, 3'b000, 1'b0);

      // Round robin from a fresh reset.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      status_m = 4'b0000; et_m = 3'b000;
      req = 4'b1111;
      do_job(0, 3, 1'b1, 1'b0, 3'b000, 1'b0);
      do_job(1, 3, 1'b1, 1'b0, 3'b000, 1'b0);
      do_job(2, 3, 1'b1, 1'b0, 3'b000, 1'b0);
      do_job(3, 3, 1'b1, 1'b0, 3'b000, 1'b0);
      req = 4'b0101;
      do_job(0, 3, 1'b1, 1'b0, 3'b000, 1'b0);
      do_job(2, 3, 1'b1, 1'b0, 3'b000, 1'b0);

      // Error and done together: error wins. Pointer at 2, so channel 1 is next.
      req = 4'b0010;
      do_job(1, 2, 1'b1, 1'b1, 3'b010, 1'b0);
      chk("err_status_bit", status, 4'b0010);
      chk("err_type", et, 3'b010);

      // Watchdog: the writer never answers.
      req = 4'b1000;
      status_m[3] = 1'b1;
      et_m = 3'b111;
      exp_q.push_back({4'b1000, status_m, et_m});
      @(negedge clk);
      chk("tmo_grant", router, 4'b1000);
      @(negedge clk);
      chk("tmo_resetn_high", wresetn, 1);
      repeat (7) @(negedge clk);
      chk("tmo_not_early", ack, 0);
      @(negedge clk);
      chk("tmo_ack", ack, 4'b1000);
      chk("tmo_err_type", et, 3'b111);
      req = 4'b0000;
      @(negedge clk);
      chk("tmo_rearm_busy", busy, 1);
      @(negedge clk);
      chk("tmo_idle", busy, 0);

      // Grantee drops its request in RUN, and the job still completes.
      req = 4'b0001;
      do_job(0, 4, 1'b1, 1'b0, 3'b000, 1'b1);

      // A successful job clears channel 1's error and keeps the last error type.
      req = 4'b0010;
      do_job(1, 2, 1'b1, 1'b0, 3'b101, 1'b0);
      chk("clear_status", status, 4'b1000);
      chk("keep_err_type", et, 3'b111);

      // Reset in the middle of RUN.
      req = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("midrun_router", router, 4'b0010);
      chk("midrun_resetn", wresetn, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_router", router, 0);
      chk("midrst_resetn", wresetn, 0);
      chk("midrst_ack", ack, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_status", status, 0);
      rst = 1'b0;
      status_m = 4'b0000; et_m = 3'b000;
      // The pointer is back at 3, so channel 1 beats channel 2.
      req = 4'b0110;
      do_job(1, 2, 1'b1, 1'b0, 3'b000, 1'b0);
      do_job(2, 2, 1'b1, 1'b0, 3'b000, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/painterengine_gpu_writer_scheduler.md
Name: painterengine_gpu_writer_scheduler

Overview:
- Round-robin job scheduler for the shared GPU DMA writer: arbitrates four requesters and drives the writer's one-hot router.
- Per job: holds the writer in reset while presenting the router, releases it, then waits for done, error or watchdog timeout.
- Reports per-channel completion and status, then re-arms the writer by asserting its active-low reset.
- Sits between the GPU command/channel logic and the DMA writer.

Parameters:
PARAM_TIMEOUT_CYCLES, 65535, RUN-state watchdog limit in cycles; 16-bit counter; must be ≥1.
PARAM_REARM_CYCLES, 2, cycles writer reset is held low after a job; must be ≥2.

Ports:
i_wire_clock  in  1  clock; all logic on rising edge
i_wire_reset  in  1  synchronous, active-high reset
i_wire_request  in  4  per-channel job request, level; held until the matching ack
o_wire_ack  out  4  one-cycle pulse on the granted channel when its job completes (success, error or timeout)
o_wire_status_error  out  4  per-channel error flag, updated at that channel's ack, held otherwise
o_wire_error_type  out  3  error type of the last failed job; 3'b111 = timeout
o_wire_busy  out  1  high in every state except IDLE
o_wire_grant_index  out  2  index of the current/last granted channel
o_wire_writer_router  out  4  one-hot router to writer; 0 when not granted
o_wire_writer_resetn  out  1  active-low reset to writer
i_wire_writer_done  in  1  writer done level
i_wire_writer_error  in  1  writer error level
i_wire_writer_error_type  in  3  writer error type

Behaviour:
- Reset (sync, active-high, any state, including mid-job): state=IDLE; router=0; writer_resetn=0; ack=0; status_error=0; error_type=0; busy=0; grant_index=0; rr_pointer=3 (channel 0 wins first); timeout and rearm counters=0.
- All outputs are registered.
- IDLE:
  - writer_resetn=0, router=0.
  - If any request bit is high, pick the first set bit scanning rr_pointer+1, +2, +3, +4 (mod 4).
  - Latch grant_index, set router=1<<index, busy=1, go to GRANT.
  - Request high at edge N gives router valid from N+1.
- GRANT (1 cycle):
  - router valid with writer_resetn still 0, so the writer samples the router in its routing state.
  - Next: writer_resetn=1, timeout counter=0, go to RUN.
- RUN:
  - router and grant_index stable throughout.
  - Sample writer done/error each cycle.
  - error=1: completion with error; error_type ← writer error_type. Error wins if done and error are both high.
  - else done=1: completion with success.
  - else if counter == PARAM_TIMEOUT_CYCLES-1: completion with error, error_type ← 3'b111.
  - else counter+1.
- Completion (transition RUN→REARM, same edge):
  - ack[grant_index]=1 for exactly one cycle.
  - status_error[grant_index] ← error flag.
  - writer_resetn=0, router=0, rr_pointer ← grant_index, rearm counter=0.
- REARM:
  - writer_resetn=0 for PARAM_REARM_CYCLES cycles, then go to IDLE (busy=0).
  - Requester must drop its request the cycle after it sees ack. Minimum REARM of 2 guarantees IDLE samples the dropped request.
- Latency:
  - request → router: 1 cycle.
  - router → writer_resetn high: 1 cycle.
  - writer done → ack: 1 cycle.
  - ack → next grant possible: PARAM_REARM_CYCLES+1 cycles.
- Request changes outside IDLE are ignored. A grantee dropping its request in RUN does not abort the job.
- Only one ack bit is ever high. status_error bits of other channels are unchanged.
- Done/error inputs are ignored outside RUN.

Test Plan:
- Single job: request=4'b0001, done after 10 cycles → router=0001 at N+1, resetn=1 at N+2, ack=0001 one cycle after done, status_error[0]=0, busy drops after 2 REARM cycles.
- Round-robin: request=4'b1111 held, each job done after 3 cycles, each requester drops its request after ack → grants in order 0,1,2,3. Then re-raise 4'b0101 → grant 0, then 2.
- Error priority: RUN with done=1 and error=1 together, error_type=3'b010 → ack pulse, status_error[idx]=1, error_type=3'b010.
- Timeout: PARAM_TIMEOUT_CYCLES=8, writer never responds → ack exactly 8 RUN cycles after resetn rises, error_type=3'b111.
- Reset mid-RUN: assert i_wire_reset while router=0010 → next edge router=0, writer_resetn=0, ack=0, busy=0. After release, request 4'b0010 → grant channel 1 (rr_pointer back to 3).
- Ignored inputs: done pulses in IDLE/REARM → no ack. Grantee drops request in RUN → job continues until done.
